// File: rtl/button_conditioner.sv
// Per-channel debounce, press/release pulse and auto-repeat for raw push-buttons.
// Define BTN_AUTOREPEAT_EN to build the hold counters that drive btn_repeat.
module button_conditioner #(
    parameter int NUM_BTN         = 5,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic               InputClock,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_repeat
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BTN-1:0] sync_p0;
    logic [NUM_BTN-1:0] sync_p1;
    logic [CW-1:0]      cnt [NUM_BTN];
    logic [NUM_BTN-1:0] diff;
    logic [NUM_BTN-1:0] accept;

    // Stage p0/p1: two-flop synchronizer for the asynchronous raw levels
    always_ff @(posedge InputClock) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
        end
    end

    always_comb begin
        diff   = sync_p1 ^ btn_level;
        accept = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            accept[i] = diff[i] && (cnt[i] == CNT_LAST);
        end
    end

    // Debounce stage: level toggles on the edge where the mismatch has lasted DEBOUNCE_CYCLES
    always_ff @(posedge InputClock) begin
        if (rst) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt[i] <= '0;
            end
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (!diff[i] || accept[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
            btn_level   <= btn_level ^ accept;
            btn_press   <= accept & ~btn_level;
            btn_release <= accept & btn_level;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int            RMAX       = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int            HW         = $clog2(RMAX + 1);
    localparam logic [HW-1:0] DELAY_LAST = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0] RATE_LAST  = HW'(REPEAT_RATE - 1);

    logic [HW-1:0]      hold [NUM_BTN];
    logic [NUM_BTN-1:0] rate_phase;
    logic [NUM_BTN-1:0] rep_hit;

    // A falling level is excluded here so no pulse lands in the release cycle
    always_comb begin
        rep_hit = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            rep_hit[i] = btn_level[i] && !accept[i] &&
                         (hold[i] == (rate_phase[i] ? RATE_LAST : DELAY_LAST));
        end
    end

    // Repeat stage: hold counter restarts each period, so it never runs past its limit
    always_ff @(posedge InputClock) begin
        if (rst) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                hold[i] <= '0;
            end
            rate_phase <= '0;
            btn_repeat <= '0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (!btn_level[i] || accept[i]) begin
                    hold[i]       <= '0;
                    rate_phase[i] <= 1'b0;
                end else if (rep_hit[i]) begin
                    hold[i]       <= '0;
                    rate_phase[i] <= 1'b1;
                end else begin
                    hold[i] <= hold[i] + HW'(1);
                end
            end
            btn_repeat <= rep_hit;
        end
    end
`else
    assign btn_repeat = '0;
`endif

endmodule
